// File: rtl/score_bcd_conv_if.sv
// rtl/score_bcd_conv_if.sv - Request/result bundle between game_control, the converter and the score renderer.
interface score_bcd_conv_if #(
  parameter int IN_WIDTH   = 32,
  parameter int NUM_DIGITS = 10
);
  logic [IN_WIDTH-1:0]     score_in;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    overflow;

  modport master (
    output score_in, start,
    input  busy, done, digits, blank, overflow
  );

  modport slave (
    input  score_in, start,
    output busy, done, digits, blank, overflow
  );
endinterface

// File: rtl/score_bcd_conv.sv
// rtl/score_bcd_conv.sv - Sequential binary-to-BCD score converter (shift-and-add-3, one bit per cycle).
// Define SCORE_LEADING_ZERO_BLANK_EN to blank leading zero digits; otherwise blank is tied low.
module score_bcd_conv #(
  parameter int IN_WIDTH   = 32,
  parameter int NUM_DIGITS = 10
) (
  input logic             clk,
  input logic             rst,
  score_bcd_conv_if.slave bus
);
  localparam int AW = 4 * (NUM_DIGITS + 1);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state, state_next;
  logic [IN_WIDTH-1:0]    sreg, sreg_next;
  logic [AW-1:0]          acc, acc_adj, acc_next;
  logic [AW+IN_WIDTH-1:0] shifted;
  logic [CW-1:0]          cnt;
  logic [DW-1:0]          digits_final, digits_q;
  logic                   ovf_final, ovf_q;
  logic                   last_shift;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT: begin
        bus.busy = 1'b1;
        if (cnt == CW'(1)) state_next = COMMIT;
      end
      COMMIT: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  assign shifted   = {acc_adj, sreg} << 1;
  assign acc_next  = shifted[AW+IN_WIDTH-1:IN_WIDTH];
  assign sreg_next = shifted[IN_WIDTH-1:0];

  // Results are captured on the final shift edge so they are already visible while done is high.
  assign last_shift   = (state == SHIFT) && (cnt == CW'(1));
  assign ovf_final    = |acc_next[AW-1 -: 4];
  assign digits_final = ovf_final ? {NUM_DIGITS{4'h9}} : acc_next[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        sreg <= bus.score_in;
        acc  <= '0;
        cnt  <= CW'(IN_WIDTH);
      end else if (state == SHIFT) begin
        sreg <= sreg_next;
        acc  <= acc_next;
        cnt  <= cnt - CW'(1);
      end
      if (last_shift) begin
        digits_q <= digits_final;
        ovf_q    <= ovf_final;
      end
    end
  end

  assign bus.digits   = digits_q;
  assign bus.overflow = ovf_q;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_final, blank_q;
  logic                  zero_above;

  // Walk down from the most significant digit; digit 0 is never blanked.
  always_comb begin
    blank_final = '0;
    zero_above  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above     = zero_above && (digits_final[4*i +: 4] == 4'd0);
      blank_final[i] = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             blank_q <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    else if (last_shift) blank_q <= blank_final;
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif
endmodule

// File: tb/tb_score_bcd_conv.sv
// tb/tb_score_bcd_conv.sv - Self-checking bench for score_bcd_conv against a decimal-arithmetic reference model.
module tb_score_bcd_conv;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_bcd_conv_if #(.IN_WIDTH(32), .NUM_DIGITS(10)) bus ();
  score_bcd_conv_if #(.IN_WIDTH(16), .NUM_DIGITS(4))  sbus ();

  score_bcd_conv #(.IN_WIDTH(32), .NUM_DIGITS(10)) dut   (.clk(clk), .rst(rst), .bus(bus));
  score_bcd_conv #(.IN_WIDTH(16), .NUM_DIGITS(4))  dut_s (.clk(clk), .rst(rst), .bus(sbus));

  int          checks = 0;
  int          errors = 0;
  logic [39:0] last_digits = '0;

  function automatic void model(input longint unsigned v, input int nd,
                                output logic [63:0] dig, output logic ovf, output logic [15:0] blk);
    longint unsigned maxv = 1;
    longint unsigned t;
    for (int i = 0; i < nd; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    dig = '0;
    blk = '0;
    ovf = (v > maxv);
    t = v;
    for (int i = 0; i < nd; i++) begin
      if (ovf) dig[4*i +: 4] = 4'd9;
      else     dig[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (!ovf) begin
      int nsig = 1;
      t = v;
      while (t >= 10) begin
        t = t / 10;
        nsig++;
      end
      for (int i = nsig; i < nd; i++) blk[i] = 1'b1;
    end
`endif
  endfunction

  task automatic convert(input logic [31:0] v, input int chg_k, input logic [31:0] chg_v, input int pulse_k,
                         output int lat, output int busy_cnt, output int done_cnt, output bit hold_ok);
    bus.score_in = v;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_cnt = 0; done_cnt = 0; hold_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat == 0) lat = k;
      end else if (lat == 0 && bus.digits !== last_digits) hold_ok = 1'b0;
      bus.start = (k == pulse_k);
      if (k == chg_k) bus.score_in = chg_v;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] ed; logic eo; logic [15:0] eb;
    model(0, 10, ed, eo, eb);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", bus.busy, bus.done); end
    checks++; if (bus.digits !== 40'h0 || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL reset_data: digits=%h ovf=%b, required 0 0", bus.digits, bus.overflow); end
    checks++; if (bus.blank !== eb[9:0]) begin errors++;
      $display("FAIL reset_blank: got %h, required %h", bus.blank, eb[9:0]); end
    checks++; if (sbus.digits !== 16'h0 || sbus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_small: digits=%h busy=%b, required 0 0", sbus.digits, sbus.busy); end
    last_digits = '0;
  endtask

  task automatic test_conversions();
    logic [31:0] vals[$];
    logic [63:0] ed; logic eo; logic [15:0] eb;
    int lat, bc, dc; bit hold;
    vals = '{32'd0, 32'd1234, 32'hFFFFFFFF, 32'd9, 32'd10, 32'd99999, 32'd1000000000};
    for (int i = 0; i < 6; i++) vals.push_back($urandom());
    for (int i = 0; i < 6; i++) vals.push_back($urandom_range(0, 99999));
    foreach (vals[n]) begin
      model(vals[n], 10, ed, eo, eb);
      convert(vals[n], 0, 0, 0, lat, bc, dc, hold);
      checks++; if (lat !== 33 || dc !== 1) begin errors++;
        $display("FAIL conv_latency v=%0d: lat=%0d pulses=%0d, required 33 1", vals[n], lat, dc); end
      checks++; if (bc !== 33) begin errors++;
        $display("FAIL conv_busy v=%0d: busy cycles=%0d, required 33", vals[n], bc); end
      checks++; if (!hold) begin errors++;
        $display("FAIL conv_hold v=%0d: digits changed before done, required %h held", vals[n], last_digits); end
      checks++; if (bus.digits !== ed[39:0]) begin errors++;
        $display("FAIL conv_digits v=%0d: got %h, required %h", vals[n], bus.digits, ed[39:0]); end
      checks++; if (bus.overflow !== eo) begin errors++;
        $display("FAIL conv_ovf v=%0d: got %b, required %b", vals[n], bus.overflow, eo); end
      checks++; if (bus.blank !== eb[9:0]) begin errors++;
        $display("FAIL conv_blank v=%0d: got %h, required %h", vals[n], bus.blank, eb[9:0]); end
      last_digits = ed[39:0];
    end
  endtask

  task automatic test_ignored_start();
    logic [63:0] ed; logic eo; logic [15:0] eb;
    int lat, bc, dc; bit hold;
    model(500, 10, ed, eo, eb);
    convert(32'd500, 5, 32'd999, 10, lat, bc, dc, hold);
    checks++; if (lat !== 33 || dc !== 1) begin errors++;
      $display("FAIL ignore_start_pulses: lat=%0d pulses=%0d, required 33 1", lat, dc); end
    checks++; if (bus.digits !== ed[39:0]) begin errors++;
      $display("FAIL ignore_start_digits: got %h, required %h", bus.digits, ed[39:0]); end
    last_digits = ed[39:0];
  endtask

  task automatic test_back_to_back();
    logic [63:0] ed; logic eo; logic [15:0] eb;
    int k;
    model(314, 10, ed, eo, eb);
    bus.score_in = 32'd314;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 1;
    while (!bus.done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (bus.done !== 1'b1 || k !== 33 || bus.digits !== ed[39:0]) begin errors++;
      $display("FAIL b2b_first: done=%b at %0d digits=%h, required 1 at 33 digits=%h", bus.done, k, bus.digits, ed[39:0]); end
    bus.start    = 1'b1;
    bus.score_in = 32'd999;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL b2b_commit_start: busy=%b after start in done cycle, required 0", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    model(999, 10, ed, eo, eb);
    k = 1;
    while (!bus.done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (bus.done !== 1'b1 || k !== 33 || bus.digits !== ed[39:0]) begin errors++;
      $display("FAIL b2b_second: done=%b at %0d digits=%h, required 1 at 33 digits=%h", bus.done, k, bus.digits, ed[39:0]); end
    @(posedge clk); #1;
    last_digits = ed[39:0];
  endtask

  task automatic test_reset_abort();
    logic [63:0] ed; logic eo; logic [15:0] eb;
    int lat, bc, dc; bit hold, seen;
    seen = 1'b0;
    bus.score_in = 32'd777;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done) seen = 1'b1;
      rst = (k == 10);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model(0, 10, ed, eo, eb);
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL abort_done: done pulse seen=%b, required 0", seen); end
    checks++; if (bus.digits !== 40'h0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin errors++;
      $display("FAIL abort_state: digits=%h busy=%b ovf=%b, required 0 0 0", bus.digits, bus.busy, bus.overflow); end
    checks++; if (bus.blank !== eb[9:0]) begin errors++;
      $display("FAIL abort_blank: got %h, required %h", bus.blank, eb[9:0]); end
    last_digits = '0;
    model(42, 10, ed, eo, eb);
    convert(32'd42, 0, 0, 0, lat, bc, dc, hold);
    checks++; if (bus.digits !== ed[39:0] || lat !== 33) begin errors++;
      $display("FAIL abort_restart: digits=%h lat=%0d, required %h 33", bus.digits, lat, ed[39:0]); end
    last_digits = ed[39:0];
  endtask

  task automatic test_small_width();
    logic [15:0] vals[$];
    logic [63:0] ed; logic eo; logic [15:0] eb;
    int lat;
    vals = '{16'd12345, 16'd9999, 16'd0, 16'd65535, 16'd10000, 16'd7};
    for (int i = 0; i < 6; i++) vals.push_back(16'($urandom_range(0, 65535)));
    foreach (vals[n]) begin
      model(vals[n], 4, ed, eo, eb);
      sbus.score_in = vals[n];
      sbus.start    = 1'b1;
      @(posedge clk); #1;
      sbus.start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 24; k++) begin
        if (sbus.done && lat == 0) lat = k;
        @(posedge clk); #1;
      end
      checks++; if (lat !== 17) begin errors++;
        $display("FAIL small_latency v=%0d: lat=%0d, required 17", vals[n], lat); end
      checks++; if (sbus.digits !== ed[15:0] || sbus.overflow !== eo) begin errors++;
        $display("FAIL small_result v=%0d: digits=%h ovf=%b, required %h %b", vals[n], sbus.digits, sbus.overflow, ed[15:0], eo); end
      checks++; if (sbus.blank !== eb[3:0]) begin errors++;
        $display("FAIL small_blank v=%0d: got %h, required %h", vals[n], sbus.blank, eb[3:0]); end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.score_in  = '0;
    sbus.start    = 1'b0;
    sbus.score_in = '0;
    test_reset();
    test_conversions();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    test_small_width();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
